// File: rtl/expu_sum_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : expu_sum_acc
// Purpose  : Softmax denominator accumulator. Converts strobed FP exp lanes to
//            unsigned fixed point, reduces them and sums across beats per vector.
// Revision : 1.0  initial release
// ============================================================================
module expu_sum_acc #(
   parameter int unsigned EXP_BITS  = 8,   // bfloat16 (FP16ALT) input format
   parameter int unsigned MAN_BITS  = 7,
   parameter int unsigned N_ROWS    = 1,
   parameter int unsigned FRAC_BITS = 24,
   parameter int unsigned ACC_WIDTH = 40,
   parameter int unsigned CNT_WIDTH = 16,
   parameter type         TAG_TYPE  = logic,
   localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clear_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [N_ROWS-1:0]             strb_i,
   input  logic [N_ROWS-1:0][WIDTH-1:0]  op_i,
   input  logic                          last_i,
   input  TAG_TYPE                       tag_i,
   output logic                          sum_valid_o,
   input  logic                          sum_ready_i,
   output logic [ACC_WIDTH-1:0]          sum_o,
   output logic [CNT_WIDTH-1:0]          sum_cnt_o,
   output logic                          sum_sat_o,
   output logic                          sum_err_o,
   output TAG_TYPE                       sum_tag_o,
   output logic                          busy_o
);

   localparam int unsigned LANE_W  = FRAC_BITS + 1;
   localparam int unsigned POP_W   = $clog2(N_ROWS + 1);
   localparam int unsigned TREE_W  = LANE_W + POP_W;
   localparam int unsigned EXT_W   = ((ACC_WIDTH > TREE_W) ? ACC_WIDTH : TREE_W) + 1;
   localparam int unsigned CNT_EXT = CNT_WIDTH + 1;
   localparam int          BIAS    = int'((1 << (EXP_BITS - 1)) - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Returns {err, fixed-point lane}; truncates bits shifted below the LSB.
   function automatic logic [LANE_W:0] conv_lane(input logic [WIDTH-1:0] v);
      logic [EXP_BITS-1:0] ex;
      logic [LANE_W-1:0]   mant;
      int                  e;
      int                  sh;
      ex        = v[WIDTH-2 -: EXP_BITS];
      mant      = LANE_W'({1'b1, v[MAN_BITS-1:0]});
      conv_lane = '0;
      e         = 0;
      sh        = 0;
      if (ex == '0) begin
         conv_lane = '0;
      end else if ((ex == '1) || v[WIDTH-1]) begin
         conv_lane = {1'b1, {LANE_W{1'b0}}};
      end else begin
         e = int'(ex) - BIAS;
         if (e >= 1) begin
            conv_lane = {1'b1, {LANE_W{1'b1}}};
         end else begin
            sh = int'(FRAC_BITS) + e - int'(MAN_BITS);
            if (sh >= 0)
               conv_lane = {1'b0, mant << sh};
            else if (sh > -int'(LANE_W))
               conv_lane = {1'b0, mant >> (-sh)};
         end
      end
   endfunction

   state_e                         state_q, state_d;
   logic                           s1_valid_q;
   logic [N_ROWS-1:0][LANE_W-1:0]  s1_lane_q, s1_lane_d;
   logic [N_ROWS-1:0]              s1_strb_q;
   logic [N_ROWS-1:0]              lane_err;
   logic                           s1_err_q;
   logic                           s1_last_q;
   TAG_TYPE                        s1_tag_q;

   logic [ACC_WIDTH-1:0]           acc_q, acc_d, acc_base;
   logic [CNT_WIDTH-1:0]           cnt_q, cnt_d, cnt_base;
   logic                           err_q, err_d, err_base;
   logic                           sat_q, sat_d, sat_base;
   TAG_TYPE                        tag_q, tag_d, tag_base;

   logic [TREE_W-1:0]              tree;
   logic [POP_W-1:0]               pop;
   logic [EXT_W-1:0]               acc_sum;
   logic [CNT_EXT-1:0]             cnt_sum;
   logic                           ovf;

   logic                           s1_advance, in_fire, s2_fire, out_fire;

   assign s1_advance = (state_q == ACCUM) | sum_ready_i;
   assign ready_o    = ~s1_valid_q | s1_advance;
   assign in_fire    = valid_i & ready_o;
   assign s2_fire    = s1_valid_q & s1_advance;
   assign out_fire   = (state_q == HOLD) & sum_ready_i;

   // ---------------- Stage S1: per-lane conversion ----------------
   always_comb begin
      s1_lane_d = '0;
      lane_err  = '0;
      for (int i = 0; i < int'(N_ROWS); i++) begin
         if (strb_i[i])
            {lane_err[i], s1_lane_d[i]} = conv_lane(op_i[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_lane_q  <= '0;
         s1_strb_q  <= '0;
         s1_err_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_tag_q   <= '0;
      end else if (clear_i) begin
         s1_valid_q <= 1'b0;
         s1_lane_q  <= '0;
         s1_strb_q  <= '0;
         s1_err_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_tag_q   <= '0;
      end else if (ready_o) begin
         s1_valid_q <= valid_i;
         if (in_fire) begin
            s1_lane_q <= s1_lane_d;
            s1_strb_q <= strb_i;
            s1_err_q  <= |lane_err;
            s1_last_q <= last_i;
            s1_tag_q  <= tag_i;
         end
      end
   end

   // ---------------- Stage S2: lane reduction and accumulation ----------------
   always_comb begin
      tree = '0;
      pop  = '0;
      for (int i = 0; i < int'(N_ROWS); i++) begin
         tree = tree + TREE_W'(s1_lane_q[i]);
         pop  = pop + POP_W'(s1_strb_q[i]);
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      sat_d    = sat_q;
      tag_d    = tag_q;
      acc_base = acc_q;
      cnt_base = cnt_q;
      err_base = err_q;
      sat_base = sat_q;
      tag_base = tag_q;
      // In HOLD an advancing beat starts a fresh vector rather than adding on.
      if (state_q == HOLD) begin
         acc_base = '0;
         cnt_base = '0;
         err_base = 1'b0;
         sat_base = 1'b0;
         tag_base = '0;
      end
      acc_sum = EXT_W'(acc_base) + EXT_W'(tree);
      cnt_sum = CNT_EXT'(cnt_base) + CNT_EXT'(pop);
      ovf     = |acc_sum[EXT_W-1:ACC_WIDTH];
      if (s2_fire) begin
         acc_d   = ovf ? '1 : acc_sum[ACC_WIDTH-1:0];
         sat_d   = sat_base | ovf;
         cnt_d   = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
         err_d   = err_base | s1_err_q;
         tag_d   = s1_last_q ? s1_tag_q : tag_base;
         state_d = s1_last_q ? HOLD : ACCUM;
      end else if (out_fire) begin
         acc_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         sat_d   = 1'b0;
         tag_d   = '0;
         state_d = ACCUM;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
         tag_q   <= '0;
      end else if (clear_i) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         sat_q   <= sat_d;
         tag_q   <= tag_d;
      end
   end

   assign sum_valid_o = (state_q == HOLD);
   assign sum_o       = acc_q;
   assign sum_cnt_o   = cnt_q;
   assign sum_sat_o   = sat_q;
   assign sum_err_o   = err_q;
   assign sum_tag_o   = tag_q;
   assign busy_o      = s1_valid_q | (state_q == HOLD) | (cnt_q != '0) |
                        (|acc_q) | err_q | sat_q;

endmodule
`default_nettype wire

// File: tb/tb_expu_sum_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_expu_sum_acc
// Purpose  : Directed and random checks of expu_sum_acc against a real-valued
//            reference model; a 26-bit accumulator copy exercises saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_expu_sum_acc;

   localparam int NR = 4;
   localparam logic [63:0] MAX40 = 64'hFF_FFFF_FFFF;
   localparam logic [63:0] MAX26 = 64'h3FF_FFFF;
   typedef logic [3:0] tag_t;

   logic                  clk_i = 1'b0;
   logic                  rst_ni, clear_i, valid_i, last_i, sum_ready_i;
   logic [NR-1:0]         strb_i;
   logic [NR-1:0][15:0]   op_i;
   tag_t                  tag_i;

   logic                  ready_o, sum_valid_o, sum_sat_o, sum_err_o, busy_o;
   logic [39:0]           sum_o;
   logic [15:0]           sum_cnt_o;
   tag_t                  sum_tag_o;

   logic                  b_ready_o, b_sum_valid_o, b_sum_sat_o, b_sum_err_o, b_busy_o;
   logic [25:0]           b_sum_o;
   logic [15:0]           b_sum_cnt_o;
   tag_t                  b_sum_tag_o;

   always #5 clk_i = ~clk_i;

   expu_sum_acc #(.N_ROWS(NR), .TAG_TYPE(tag_t)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
      .ready_o(ready_o), .strb_i(strb_i), .op_i(op_i), .last_i(last_i),
      .tag_i(tag_i), .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i),
      .sum_o(sum_o), .sum_cnt_o(sum_cnt_o), .sum_sat_o(sum_sat_o),
      .sum_err_o(sum_err_o), .sum_tag_o(sum_tag_o), .busy_o(busy_o));

   expu_sum_acc #(.N_ROWS(NR), .ACC_WIDTH(26), .TAG_TYPE(tag_t)) dut26 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
      .ready_o(b_ready_o), .strb_i(strb_i), .op_i(op_i), .last_i(last_i),
      .tag_i(tag_i), .sum_valid_o(b_sum_valid_o), .sum_ready_i(sum_ready_i),
      .sum_o(b_sum_o), .sum_cnt_o(b_sum_cnt_o), .sum_sat_o(b_sum_sat_o),
      .sum_err_o(b_sum_err_o), .sum_tag_o(b_sum_tag_o), .busy_o(b_busy_o));

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      longint total;
      int     cnt;
      bit     err;
      tag_t   tag;
   } res_t;

   res_t   exp_q[$];
   longint m_total = 0;
   int     m_cnt   = 0;
   bit     m_err   = 1'b0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
      end
   endtask

   function automatic logic [63:0] clampv(input longint t, input logic [63:0] mx);
      return (t > longint'(mx)) ? mx : 64'(t);
   endfunction

   // Real value of a bfloat16 lane scaled by 2^24, floor-truncated.
   function automatic longint ref_lane(input logic [15:0] v, output bit err);
      int  ex;
      int  m;
      real x;
      ex  = int'(v[14:7]);
      m   = int'(v[6:0]);
      err = 1'b0;
      if (ex == 0) return 0;
      if (ex == 255 || v[15]) begin
         err = 1'b1;
         return 0;
      end
      x = 1.0 + real'(m) / 128.0;
      for (int k = ex; k < 127; k++) x = x / 2.0;
      for (int k = 127; k < ex; k++) x = x * 2.0;
      if (x >= 2.0) begin
         err = 1'b1;
         return 64'd33554431;
      end
      return longint'($rtoi(x * 16777216.0));
   endfunction

   task automatic model_clear();
      m_total = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
   endtask

   task automatic model_accept(input logic [NR-1:0][15:0] d, input logic [NR-1:0] s,
                               input bit l, input tag_t t);
      bit   e;
      res_t r;
      for (int i = 0; i < NR; i++) begin
         if (s[i]) begin
            m_total += ref_lane(d[i], e);
            m_err   |= e;
            m_cnt++;
         end
      end
      if (l) begin
         r.total = m_total;
         r.cnt   = m_cnt;
         r.err   = m_err;
         r.tag   = t;
         exp_q.push_back(r);
         model_clear();
      end
   endtask

   // All drives and samples happen 1 ns after the rising edge unless noted.
   task automatic send_beat(input logic [NR-1:0][15:0] d, input logic [NR-1:0] s,
                            input bit l, input tag_t t);
      bit ok;
      ok      = 1'b0;
      valid_i = 1'b1;
      op_i    = d;
      strb_i  = s;
      last_i  = l;
      tag_i   = t;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk_i);
         ok = ready_o;
         @(posedge clk_i);
         #1;
      end
      if (ok) model_accept(d, s, l, t);
      else    chk("send_timeout", 64'd0, 64'd1);
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok;
      ok = sum_valid_o;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(posedge clk_i);
         #1;
         ok = sum_valid_o;
      end
      if (!ok) chk("valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_result();
      res_t r;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 64'd1, 64'd0);
         return;
      end
      r = exp_q[0];
      chk("sum_valid", 64'(sum_valid_o), 64'd1);
      chk("sum",       64'(sum_o),       clampv(r.total, MAX40));
      chk("sat",       64'(sum_sat_o),   64'(r.total > longint'(MAX40)));
      chk("cnt",       64'(sum_cnt_o),   64'(r.cnt));
      chk("err",       64'(sum_err_o),   64'(r.err));
      chk("tag",       64'(sum_tag_o),   64'(r.tag));
      chk("sum26",     64'(b_sum_o),     clampv(r.total, MAX26));
      chk("sat26",     64'(b_sum_sat_o), 64'(r.total > longint'(MAX26)));
   endtask

   task automatic expect_result();
      res_t r;
      wait_valid();
      check_result();
      if (exp_q.size() != 0) r = exp_q.pop_front();
      sum_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      sum_ready_i = 1'b0;
   endtask

   initial begin
      logic [NR-1:0][15:0] d;
      logic [NR-1:0]       s;
      res_t                r;
      int                  nb;

      rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      sum_ready_i = 1'b0; strb_i = '0; op_i = '0; tag_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      // Reset state
      chk("rst_ready", 64'(ready_o),     64'd1);
      chk("rst_valid", 64'(sum_valid_o), 64'd0);
      chk("rst_sum",   64'(sum_o),       64'd0);
      chk("rst_cnt",   64'(sum_cnt_o),   64'd0);
      chk("rst_busy",  64'(busy_o),      64'd0);
      chk("rst_flags", 64'({sum_sat_o, sum_err_o, sum_tag_o}), 64'd0);

      // Single beat 1.0+0.5+0.25+0.25, with latency check
      d = {16'h3E80, 16'h3E80, 16'h3F00, 16'h3F80};
      send_beat(d, 4'b1111, 1'b1, 4'd1);
      chk("lat_t1", 64'(sum_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("lat_t2",  64'(sum_valid_o), 64'd1);
      chk("t1_sum",  64'(sum_o),       64'h2000000);
      chk("t1_cnt",  64'(sum_cnt_o),   64'd4);
      expect_result();

      // Two-beat vector with partial strobe
      send_beat(d, 4'b0101, 1'b0, 4'd0);
      d = {4{16'h3F80}};
      send_beat(d, 4'b1111, 1'b1, 4'd2);
      wait_valid();
      chk("t2_sum", 64'(sum_o),     64'h5400000);
      chk("t2_cnt", 64'(sum_cnt_o), 64'd6);
      expect_result();

      // Negative, NaN, >=2.0, denormal lanes
      d = {16'h0001, 16'h4000, 16'h7FC0, 16'hBF80};
      send_beat(d, 4'b1111, 1'b1, 4'd3);
      wait_valid();
      chk("t3_sum", 64'(sum_o),     64'h1FFFFFF);
      chk("t3_err", 64'(sum_err_o), 64'd1);
      chk("t3_cnt", 64'(sum_cnt_o), 64'd4);
      expect_result();

      // Saturation of the 26-bit accumulator, then flag clears
      d = {4{16'h3F80}};
      send_beat(d, 4'b1111, 1'b0, 4'd0);
      send_beat(d, 4'b1111, 1'b0, 4'd0);
      send_beat(d, 4'b1111, 1'b1, 4'd4);
      wait_valid();
      chk("t4_sum26", 64'(b_sum_o),     64'h3FFFFFF);
      chk("t4_sat26", 64'(b_sum_sat_o), 64'd1);
      expect_result();
      send_beat(d, 4'b0001, 1'b1, 4'd5);
      wait_valid();
      chk("t4_clr_sat26", 64'(b_sum_sat_o), 64'd0);
      expect_result();

      // Back-pressure in HOLD: one beat parks in S1, then zero-bubble reload
      d = {16'h3F00, 16'h3F00, 16'h3F00, 16'h3F80};
      send_beat(d, 4'b1001, 1'b1, 4'd6);
      wait_valid();
      d = {4{16'h3F00}};
      valid_i = 1'b1; op_i = d; strb_i = 4'b1111; last_i = 1'b0; tag_i = 4'd0;
      @(negedge clk_i);
      chk("hold_first_ready", 64'(ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      model_accept(d, 4'b1111, 1'b0, 4'd0);
      d = {4{16'h3F80}};
      op_i = d; strb_i = 4'b0011; last_i = 1'b1; tag_i = 4'd7;
      r = exp_q[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         chk("hold_ready",   64'({ready_o, b_ready_o}), 64'd0);
         chk("hold_sum_stb", 64'(sum_o), clampv(r.total, MAX40));
         @(posedge clk_i);
         #1;
      end
      check_result();
      sum_ready_i = 1'b1;
      @(negedge clk_i);
      chk("release_ready", 64'(ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      r = exp_q.pop_front();
      model_accept(d, 4'b0011, 1'b1, 4'd7);
      sum_ready_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      chk("release_valid", 64'(sum_valid_o), 64'd0);
      chk("release_busy",  64'(busy_o),      64'd1);
      expect_result();

      // clear_i mid-vector
      send_beat(d, 4'b1111, 1'b0, 4'd0);
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      model_clear();
      chk("clr_valid", 64'(sum_valid_o), 64'd0);
      chk("clr_busy",  64'(busy_o),      64'd0);
      d = {16'h0000, 16'h0000, 16'h3F00, 16'h3F00};
      send_beat(d, 4'b0011, 1'b1, 4'd8);
      expect_result();

      // clear_i in HOLD discards the pending result
      send_beat(d, 4'b1111, 1'b1, 4'd9);
      wait_valid();
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
      if (exp_q.size() != 0) r = exp_q.pop_front();
      chk("clrh_valid", 64'(sum_valid_o), 64'd0);
      chk("clrh_busy",  64'(busy_o),      64'd0);

      // Asynchronous reset mid-vector, then an all-unstrobed closing beat
      d = {4{16'h3F80}};
      send_beat(d, 4'b1111, 1'b0, 4'd0);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("arst_busy",  64'(busy_o),  64'd0);
      chk("arst_ready", 64'(ready_o), 64'd1);
      chk("arst_sum",   64'(sum_o),   64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      model_clear();
      send_beat(d, 4'b0000, 1'b1, 4'd10);
      wait_valid();
      chk("zero_sum", 64'(sum_o),     64'd0);
      chk("zero_cnt", 64'(sum_cnt_o), 64'd0);
      expect_result();

      // Random vectors
      for (int v = 0; v < 24; v++) begin
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < NR; i++) begin
               if ($urandom_range(0, 3) == 0)
                  d[i] = 16'($urandom);
               else
                  d[i] = {1'b0, 8'($urandom_range(110, 127)), 7'($urandom)};
            end
            s = 4'($urandom);
            send_beat(d, s, (b == nb - 1), 4'($urandom));
         end
         expect_result();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
